// File: rtl/ecc_tcdm_bank_responder.sv
// ECC-protected TCDM bank responder: serves SECDED(39,32) encoded requests from one single-port
// SRAM bank and uses read-modify-write for partial writes. Optional read scrubbing: ECC_TCDM_SCRUB_EN.
module ecc_tcdm_bank_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [3:0]            be_i,
  input  logic [38:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [38:0]           r_rdata_o,
  output logic                  r_opc_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [38:0]           sram_wdata_o,
  input  logic [38:0]           sram_rdata_i,
  output logic [15:0]           err_corr_cnt_o,
  output logic [15:0]           err_uncorr_cnt_o,
  input  logic                  cnt_clr_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RMW_WRITE = 2'd1
`ifdef ECC_TCDM_SCRUB_EN
    , SCRUB_WRITE = 2'd2
`endif
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        corr;
    logic        uncorr;
  } dec_t;

  // Word layout: [31:0] data, [37:32] Hamming check bits, [38] overall parity.
  function automatic logic [5:0] hpos(input int idx);
    logic [5:0] res;
    int         n;
    res = 6'd0;
    n   = 0;
    for (int p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) res = p[5:0];
        n++;
      end
    end
    return res;
  endfunction

  function automatic logic [38:0] secded_enc(input logic [31:0] d);
    logic [5:0] c;
    c = 6'd0;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) c = c ^ hpos(i);
    end
    return {^{c, d}, c, d};
  endfunction

  function automatic dec_t secded_dec(input logic [38:0] w);
    dec_t       r;
    logic [5:0] syn;
    syn = w[37:32];
    for (int i = 0; i < 32; i++) begin
      if (w[i]) syn = syn ^ hpos(i);
    end
    r.data   = w[31:0];
    r.corr   = 1'b0;
    r.uncorr = 1'b0;
    if (^w) begin
      // Odd parity is a single flip unless the syndrome points past the last position.
      if (syn > 6'd38) begin
        r.uncorr = 1'b1;
      end else begin
        r.corr = 1'b1;
        for (int i = 0; i < 32; i++) begin
          if (syn == hpos(i)) r.data[i] = ~w[i];
        end
      end
    end else if (syn != 6'd0) begin
      r.uncorr = 1'b1;
    end
    return r;
  endfunction

  state_t                state_r, state_n;
  logic                  wr_pend_r, wr_pend_n;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [3:0]            be_r;
  logic [31:0]           wdata_r;
  logic                  wbad_r;
  logic [15:0]           corr_cnt_r, uncorr_cnt_r;
  logic                  rd_resp_s, idle_s, self_wr_s, accept_s, rmw_start_s;
  logic                  corr_evt_s, uncorr_evt_s;
  logic [31:0]           merged_s;
  dec_t                  rd_dec_s, wd_dec_s;

`ifdef ECC_TCDM_SCRUB_EN
  assign rd_resp_s = (state_r == SCRUB_WRITE);
  assign idle_s    = (state_r == IDLE) || (state_r == SCRUB_WRITE);
`else
  logic rd_pend_r, rd_pend_n;
  assign rd_resp_s = rd_pend_r;
  assign idle_s    = (state_r == IDLE);
`endif

  assign rd_dec_s         = secded_dec(sram_rdata_i);
  assign wd_dec_s         = secded_dec(wdata_i);
  assign err_corr_cnt_o   = corr_cnt_r;
  assign err_uncorr_cnt_o = uncorr_cnt_r;

  // Merge the enabled new bytes over the corrected old word.
  always_comb begin
    merged_s = rd_dec_s.data;
    for (int b = 0; b < 4; b++) begin
      if (be_r[b]) merged_s[8*b +: 8] = wdata_r[8*b +: 8];
      else         merged_s[8*b +: 8] = rd_dec_s.data[8*b +: 8];
    end
  end

  // Next state, response, bank access and grant.
  always_comb begin
    state_n      = IDLE;
    wr_pend_n    = 1'b0;
`ifndef ECC_TCDM_SCRUB_EN
    rd_pend_n    = 1'b0;
`endif
    r_valid_o    = 1'b0;
    r_rdata_o    = 39'd0;
    r_opc_o      = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = add_i;
    sram_wdata_o = wdata_i;
    corr_evt_s   = 1'b0;
    uncorr_evt_s = 1'b0;
    self_wr_s    = 1'b0;
    rmw_start_s  = 1'b0;
    if (rst_i) begin
      state_n = IDLE;
    end else if (rd_resp_s) begin
      r_valid_o    = 1'b1;
      r_rdata_o    = sram_rdata_i;
      r_opc_o      = rd_dec_s.uncorr;
      corr_evt_s   = rd_dec_s.corr;
      uncorr_evt_s = rd_dec_s.uncorr;
`ifdef ECC_TCDM_SCRUB_EN
      if (rd_dec_s.corr) begin
        r_rdata_o    = secded_enc(rd_dec_s.data);
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = addr_r;
        sram_wdata_o = secded_enc(rd_dec_s.data);
        self_wr_s    = 1'b1;
      end else begin
        self_wr_s    = 1'b0;
      end
`endif
    end else if (wr_pend_r) begin
      r_valid_o = 1'b1;
    end else if (state_r == RMW_WRITE) begin
      r_valid_o    = 1'b1;
      r_opc_o      = rd_dec_s.uncorr | wbad_r;
      corr_evt_s   = rd_dec_s.corr;
      uncorr_evt_s = rd_dec_s.uncorr;
      if (!(rd_dec_s.uncorr | wbad_r)) begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = addr_r;
        sram_wdata_o = secded_enc(merged_s);
        self_wr_s    = 1'b1;
      end else begin
        self_wr_s    = 1'b0;
      end
    end else begin
      r_valid_o = 1'b0;
    end

    gnt_o    = req_i && idle_s && !self_wr_s;
    accept_s = gnt_o && !rst_i;
    if (accept_s) begin
      if (wen_i) begin
        sram_req_o = 1'b1;
`ifdef ECC_TCDM_SCRUB_EN
        state_n    = SCRUB_WRITE;
`else
        rd_pend_n  = 1'b1;
`endif
      end else if (be_i == 4'hF) begin
        sram_req_o = 1'b1;
        sram_we_o  = 1'b1;
        wr_pend_n  = 1'b1;
      end else if (be_i == 4'h0) begin
        wr_pend_n  = 1'b1;
      end else begin
        sram_req_o  = 1'b1;
        rmw_start_s = 1'b1;
        state_n     = RMW_WRITE;
      end
    end else begin
      rmw_start_s = 1'b0;
    end
  end

  // State and pending-response registers; request fields captured on every accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      wr_pend_r <= 1'b0;
`ifndef ECC_TCDM_SCRUB_EN
      rd_pend_r <= 1'b0;
`endif
      addr_r    <= '0;
      be_r      <= 4'h0;
      wdata_r   <= 32'd0;
      wbad_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      wr_pend_r <= wr_pend_n;
`ifndef ECC_TCDM_SCRUB_EN
      rd_pend_r <= rd_pend_n;
`endif
      if (accept_s) addr_r <= add_i;
      if (rmw_start_s) begin
        be_r    <= be_i;
        wdata_r <= wd_dec_s.data;
        wbad_r  <= wd_dec_s.uncorr;
      end
    end
  end

  // Saturating error counters; clear wins over increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      corr_cnt_r   <= 16'd0;
      uncorr_cnt_r <= 16'd0;
    end else begin
      if (corr_evt_s && corr_cnt_r != 16'hFFFF) corr_cnt_r <= corr_cnt_r + 16'd1;
      if (uncorr_evt_s && uncorr_cnt_r != 16'hFFFF) uncorr_cnt_r <= uncorr_cnt_r + 16'd1;
    end
  end

endmodule

// File: doc/ecc_tcdm_bank_responder.md
# ecc_tcdm_bank_responder

Responder-side endpoint of the ECC-protected TCDM link: accepts requests carrying 39-bit SECDED-encoded write data (32 data + 7 check bits) from the initiator-side encoder, and serves them from a single-port 39-bit SRAM bank. Read data is returned still encoded, so the initiator decodes it. Partial-byte writes need a read-modify-write sequence because check bits cover the full word. The block sits between the TCDM crossbar slave port and one memory bank macro.

## Interface
- ADDR_WIDTH, 10: word address width of the bank.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  request valid.
- add_i  in  ADDR_WIDTH  word address.
- wen_i  in  1  1 = read, 0 = write.
- be_i  in  4  byte enables for writes.
- wdata_i  in  39  SECDED(39,32)-encoded write word.
- gnt_o  out  1  request accepted this cycle.
- r_valid_o  out  1  response valid.
- r_rdata_o  out  39  encoded read data.
- r_opc_o  out  1  1 = uncorrectable error on this transaction.
- sram_req_o  out  1  bank access.
- sram_we_o  out  1  bank write.
- sram_addr_o  out  ADDR_WIDTH  bank address.
- sram_wdata_o  out  39  bank write word.
- sram_rdata_i  in  39  bank read word, valid one cycle after read access.
- err_corr_cnt_o  out  16  saturating count of corrected single-bit errors.
- err_uncorr_cnt_o  out  16  saturating count of uncorrectable errors.
- cnt_clr_i  in  1  clears both counters.

## Operation
- States: IDLE, RMW_WRITE (plus SCRUB_WRITE with the macro).
- gnt_o = req_i while in IDLE, except in a cycle in which the block itself writes the bank (RMW_WRITE or scrub write-back); then gnt_o = 0.
- Read accepted: bank read issued in the same cycle. Next cycle: r_valid_o = 1, r_rdata_o = sram_rdata_i (raw), r_opc_o = 1 if the stored word decodes as uncorrectable.
- Write with be_i = 4'hF: wdata_i written straight to bank, no decode. Next cycle: r_valid_o = 1, r_opc_o = 0.
- Write with be_i = 4'h0: no bank access. Next cycle: r_valid_o = 1, r_opc_o = 0.
- Partial write (any other be_i): in the accept cycle, issue a bank read of add_i and register add_i, be_i, and the decoded wdata_i. Then go to RMW_WRITE.
- In RMW_WRITE: decode the old word, replace the enabled bytes with new data, re-encode, write the bank, assert r_valid_o, return to IDLE.
  - If the old word or wdata_i is uncorrectable: write nothing, r_opc_o = 1.
  - A correctable error in the old word is corrected by the merge.
- Counters: +1 per decode event of each class. A read, or the old word of an RMW, counts as one event. Each counter saturates at 16'hFFFF. cnt_clr_i has priority over increment.
- The decoder is an internal SECDED(39,32) decoder with the same code as the link encoder.

## Timing
- Reset values: state IDLE, gnt_o follows req_i, r_valid_o 0, r_rdata_o 0, r_opc_o 0, sram_req_o 0, sram_we_o 0, both counters 0.
- Read / full write / be=0 write: accept in cycle N, response in N+1. Back-to-back accepts every cycle.
- Partial write: accept in N, bank write and response in N+1, gnt_o = 0 in N+1, next accept no earlier than N+2.
- r_valid_o is asserted for exactly one cycle per accepted request.
- Reset asserted mid-RMW: the pending write is dropped, no bank write, r_valid_o = 0 in the following cycle.
- gnt_o is combinational from req_i and the state (with the macro, also from the decode of sram_rdata_i).

## Configuration
- ECC_TCDM_SCRUB_EN defined: on a read whose data has a correctable error, in cycle N+1:
  - r_rdata_o returns the corrected, re-encoded word;
  - the same word is written back to the bank;
  - gnt_o = 0 in that cycle.
- Undefined: reads are pure pass-through and the bank is never written on reads.

## Test plan
- Write 0x12345678 encoded, be=F, addr 5, then read addr 5 -> r_valid_o one cycle after each gnt, r_rdata_o equals the encoded 0x12345678, r_opc_o = 0.
- Old word 0x12345678, partial write be=4'b0010 with data 0x0000AB00 -> gnt_o low in N+1, bank receives encode(0x1234AB78), readback matches.
- Flip bit 3 of the stored word, then read -> err_corr_cnt_o = 1, r_opc_o = 0. With the macro: corrected word returned and written back, and a second read counts nothing.
- Flip 2 bits of the stored word, then partial write -> no bank write, r_opc_o = 1, err_uncorr_cnt_o = 1.
- Preload counter to 16'hFFFE, inject 3 correctable errors -> counter holds at 16'hFFFF. cnt_clr_i with an error in the same cycle -> counter = 0.
- Assert rst_i in the RMW_WRITE cycle -> sram_we_o = 0, r_valid_o = 0 next cycle, bank word unchanged.
